// File: rtl/cpu_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding and default widths.
package cpu_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic {
        OWN_F  = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_arbiter_if
    import cpu_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_grant;
    logic          f_done;

    logic          ls_req;
    logic          ls_rw;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_grant;
    logic          ls_done;

    logic [DW-1:0] rdata;
    logic          timeout_err;

    logic          MEM_EN;
    logic          MEM_RW;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic          MFC;

    modport slave (
        input  f_req, f_addr, ls_req, ls_rw, ls_addr, ls_wdata, MEM_RDATA, MFC,
        output f_grant, f_done, ls_grant, ls_done, rdata, timeout_err,
               MEM_EN, MEM_RW, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output f_req, f_addr, ls_req, ls_rw, ls_addr, ls_wdata, MEM_RDATA, MFC,
        input  f_grant, f_done, ls_grant, ls_done, rdata, timeout_err,
               MEM_EN, MEM_RW, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not served last wins.
module rr_arbiter2
    import cpu_pkg::*;
(
    input  logic   f_req,
    input  logic   ls_req,
    input  owner_t last,
    output owner_t winner_c
);

    always_comb begin
        winner_c = OWN_F;
        if (f_req && ls_req) begin
            winner_c = (last == OWN_F) ? OWN_LS : OWN_F;
        end else if (ls_req) begin
            winner_c = OWN_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store: one transaction at a time,
// IDLE->SETUP->ACCESS->WAIT->DONE, with an MFC timeout that aborts the access.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    owner_t           own_q;
    owner_t           last_q;
    owner_t           winner_c;
    logic [AW-1:0]    addr_q;
    logic             rw_q;
    logic [DW-1:0]    wdata_q;
    logic [DW-1:0]    rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             abort_q;
    logic             any_req_c;
    logic             cnt_exp_c;

    logic             f_grant_c;
    logic             ls_grant_c;
    logic             f_done_c;
    logic             ls_done_c;
    logic             mem_en_c;
    logic             timeout_err_c;

    rr_arbiter2 u_rr (
        .f_req    (bus.f_req),
        .ls_req   (bus.ls_req),
        .last     (last_q),
        .winner_c (winner_c)
    );

    assign any_req_c = bus.f_req | bus.ls_req;
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign cnt_exp_c = (cnt_inc_c == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus Moore decode of grants, strobes and completion
    always_comb begin
        state_d       = state_q;
        f_grant_c     = 1'b0;
        ls_grant_c    = 1'b0;
        f_done_c      = 1'b0;
        ls_done_c     = 1'b0;
        mem_en_c      = 1'b0;
        timeout_err_c = 1'b0;

        if (state_q != ST_IDLE) begin
            f_grant_c  = (own_q == OWN_F);
            ls_grant_c = (own_q == OWN_LS);
        end

        case (state_q)
            ST_IDLE: begin
                if (any_req_c) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_en_c = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.MFC || cnt_exp_c) state_d = ST_DONE;
            end
            ST_DONE: begin
                f_done_c      = (own_q == OWN_F);
                ls_done_c     = (own_q == OWN_LS);
                timeout_err_c = abort_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transaction registers: latched request, wait counter, abort flag, read capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_q   <= OWN_F;
            last_q  <= OWN_LS;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req_c) begin
                        own_q <= winner_c;
                        if (winner_c == OWN_F) begin
                            addr_q  <= bus.f_addr;
                            rw_q    <= 1'b1;
                            wdata_q <= '0;
                        end else begin
                            addr_q  <= bus.ls_addr;
                            rw_q    <= bus.ls_rw;
                            wdata_q <= bus.ls_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_q   <= '0;
                    abort_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (!bus.MFC) begin
                        if (rw_q) rdata_q <= bus.MEM_RDATA;
                    end else begin
                        cnt_q <= cnt_inc_c;
                        if (cnt_exp_c) abort_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    last_q <= own_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.f_grant     = f_grant_c;
    assign bus.ls_grant    = ls_grant_c;
    assign bus.f_done      = f_done_c;
    assign bus.ls_done     = ls_done_c;
    assign bus.MEM_EN      = mem_en_c;
    assign bus.timeout_err = timeout_err_c;
    assign bus.MEM_ADDR    = addr_q;
    assign bus.MEM_RW      = rw_q;
    assign bus.MEM_WDATA   = wdata_q;
    assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset/tie sequences,
// then random transactions against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned TO = 15;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // Transaction-level model state: who was served last, and the last captured read data
    bit          m_last_f;
    logic [15:0] m_rdata;

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        f;
        logic        ls;
        logic        rw;
        logic [15:0] fa;
        logic [15:0] la;
        logic [15:0] wd;
        logic [15:0] mv;
        int          k;
        logic        ef;
        logic        et;
        logic [15:0] erd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string ph, input logic en, input logic fw, input logic [15:0] ea,
                             input logic erw, input logic [15:0] ewd, input logic chk_wd);
        chk1({ph, "_mem_en"}, bus.MEM_EN, en);
        chk1({ph, "_f_grant"}, bus.f_grant, fw);
        chk1({ph, "_ls_grant"}, bus.ls_grant, !fw);
        chk16({ph, "_mem_addr"}, bus.MEM_ADDR, ea);
        chk1({ph, "_mem_rw"}, bus.MEM_RW, erw);
        if (chk_wd) chk16({ph, "_mem_wdata"}, bus.MEM_WDATA, ewd);
    endtask

    task automatic check_reset_outputs(input string ph);
        chk1({ph, "_f_grant"}, bus.f_grant, 1'b0);
        chk1({ph, "_ls_grant"}, bus.ls_grant, 1'b0);
        chk1({ph, "_f_done"}, bus.f_done, 1'b0);
        chk1({ph, "_ls_done"}, bus.ls_done, 1'b0);
        chk1({ph, "_mem_en"}, bus.MEM_EN, 1'b0);
        chk1({ph, "_mem_rw"}, bus.MEM_RW, 1'b0);
        chk16({ph, "_mem_addr"}, bus.MEM_ADDR, 16'h0000);
        chk16({ph, "_mem_wdata"}, bus.MEM_WDATA, 16'h0000);
        chk16({ph, "_rdata"}, bus.rdata, 16'h0000);
        chk1({ph, "_timeout_err"}, bus.timeout_err, 1'b0);
    endtask

    // One complete transaction, entered and left #1 into an IDLE cycle.
    // k = WAIT cycle in which MFC is driven low (k > TO means never).
    task automatic do_txn(input logic f, input logic ls, input logic rw,
                          input logic [15:0] fa, input logic [15:0] la, input logic [15:0] wd,
                          input logic [15:0] mv, input int k,
                          input logic ef, input logic et, input logic [15:0] erd,
                          input bit drop_win, input bit raise_other, input bit [1:0] noise);
        logic [15:0] ea;
        logic        erw;
        int          len;
        ea  = ef ? fa : la;
        erw = ef ? 1'b1 : rw;
        len = (k > int'(TO)) ? int'(TO) : k;

        bus.f_req     = f;
        bus.ls_req    = ls;
        bus.ls_rw     = rw;
        bus.f_addr    = fa;
        bus.ls_addr   = la;
        bus.ls_wdata  = wd;
        bus.MFC       = !noise[0];
        bus.MEM_RDATA = 16'($urandom);

        @(posedge clk); #1;
        check_bus("setup", 1'b0, ef, ea, erw, wd, !erw);
        chk1("setup_done", bus.f_done | bus.ls_done, 1'b0);
        if (drop_win) begin
            if (ef) bus.f_req = 1'b0;
            else    bus.ls_req = 1'b0;
        end
        bus.MFC = !noise[1];

        @(posedge clk); #1;
        check_bus("access", 1'b1, ef, ea, erw, wd, !erw);
        if (raise_other) begin
            if (ef) bus.ls_req = 1'b1;
            else    bus.f_req = 1'b1;
        end

        for (int i = 1; i <= len; i++) begin
            @(posedge clk); #1;
            check_bus("wait", 1'b0, ef, ea, erw, wd, !erw);
            chk1("wait_done", bus.f_done | bus.ls_done, 1'b0);
            chk1("wait_timeout_err", bus.timeout_err, 1'b0);
            bus.MFC       = (i == k) ? 1'b0 : 1'b1;
            bus.MEM_RDATA = (i == k) ? mv : 16'($urandom);
        end

        @(posedge clk); #1;
        check_bus("done", 1'b0, ef, ea, erw, wd, !erw);
        chk1("done_f_done", bus.f_done, ef);
        chk1("done_ls_done", bus.ls_done, !ef);
        chk1("done_timeout_err", bus.timeout_err, et);
        chk16("done_rdata", bus.rdata, erd);
        bus.MFC    = 1'b1;
        bus.f_req  = 1'b0;
        bus.ls_req = 1'b0;

        @(posedge clk); #1;
        chk1("idle_f_grant", bus.f_grant, 1'b0);
        chk1("idle_ls_grant", bus.ls_grant, 1'b0);
        chk1("idle_done", bus.f_done | bus.ls_done, 1'b0);
        chk16("idle_rdata", bus.rdata, erd);

        m_last_f = ef;
        m_rdata  = erd;
    endtask

    initial begin
        int f_at;
        int ls_at;
        int f_cnt;
        int ls_cnt;

        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 1,  1'b1, 1'b0, 16'hBEEF};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0200, 16'h1234, 16'hDEAD, 1,  1'b0, 1'b0, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 16'h0300, 16'h0400, 16'h0000, 16'h1111, 2,  1'b1, 1'b0, 16'h1111};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0304, 16'h0404, 16'h0000, 16'h2222, 3,  1'b0, 1'b0, 16'h2222};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0500, 16'h0000, 16'h3333, 20, 1'b0, 1'b1, 16'h2222};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0600, 16'h0604, 16'h5555, 16'h4444, 15, 1'b1, 1'b0, 16'h4444};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 16'h0700, 16'h0000, 16'h0000, 16'h6666, 16, 1'b1, 1'b1, 16'h4444};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h0800, 16'h0804, 16'h7777, 16'h8888, 1,  1'b0, 1'b0, 16'h4444};

        bus.f_req     = 1'b0;
        bus.ls_req    = 1'b0;
        bus.ls_rw     = 1'b0;
        bus.f_addr    = 16'h0000;
        bus.ls_addr   = 16'h0000;
        bus.ls_wdata  = 16'h0000;
        bus.MEM_RDATA = 16'h0000;
        bus.MFC       = 1'b1;
        reset         = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_last_f = 1'b0;
        m_rdata  = 16'h0000;

        // Directed vectors, MFC held low through IDLE/SETUP/ACCESS where it must be ignored
        for (int v = 0; v < 8; v++) begin
            do_txn(vecs[v].f, vecs[v].ls, vecs[v].rw, vecs[v].fa, vecs[v].la, vecs[v].wd,
                   vecs[v].mv, vecs[v].k, vecs[v].ef, vecs[v].et, vecs[v].erd,
                   1'b0, 1'b0, 2'b11);
        end

        // Reset during WAIT: grants drop at once, no done, next tie goes to fetch
        bus.ls_req  = 1'b1;
        bus.ls_rw   = 1'b1;
        bus.ls_addr = 16'h0900;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("rst_seq_access_en", bus.MEM_EN, 1'b1);
        @(posedge clk); #1;
        chk1("rst_seq_wait_ls_grant", bus.ls_grant, 1'b1);
        bus.f_req = 1'b1;
        #1 reset = 1'b0;
        #1 check_reset_outputs("midwait_reset");
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk1("held_reset_done", bus.f_done | bus.ls_done, 1'b0);
            chk1("held_reset_grant", bus.f_grant | bus.ls_grant, 1'b0);
        end
        bus.MFC       = 1'b0;
        bus.MEM_RDATA = 16'hCAFE;
        reset         = 1'b1;

        // Back-to-back tie from reset: fetch done at cycle 4, load/store at cycle 9
        f_at   = -1;
        ls_at  = -1;
        f_cnt  = 0;
        ls_cnt = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #1;
            chk1("grant_overlap", bus.f_grant & bus.ls_grant, 1'b0);
            if (bus.f_done) begin
                f_cnt++;
                f_at = cyc;
                bus.f_req = 1'b0;
            end
            if (bus.ls_done) begin
                ls_cnt++;
                ls_at = cyc;
                bus.ls_req = 1'b0;
            end
        end
        chk16("tie_f_done_cycle", 16'(f_at), 16'd4);
        chk16("tie_ls_done_cycle", 16'(ls_at), 16'd9);
        chk16("tie_f_done_count", 16'(f_cnt), 16'd1);
        chk16("tie_ls_done_count", 16'(ls_cnt), 16'd1);
        chk16("tie_rdata", bus.rdata, 16'hCAFE);
        bus.MFC  = 1'b1;
        m_last_f = 1'b0;
        m_rdata  = 16'hCAFE;

        // Random transactions checked against the round-robin / timeout model
        for (int t = 0; t < 40; t++) begin
            logic [1:0]  r;
            logic        rf;
            logic        rls;
            logic        rrw;
            logic [15:0] rfa;
            logic [15:0] rla;
            logic [15:0] rwd;
            logic [15:0] rmv;
            int          rk;
            logic        ef;
            logic        et;
            logic [15:0] erd;
            r   = 2'($urandom_range(1, 3));
            rf  = r[0];
            rls = r[1];
            rrw = 1'($urandom);
            rfa = 16'($urandom);
            rla = 16'($urandom);
            rwd = 16'($urandom);
            rmv = 16'($urandom);
            rk  = int'($urandom_range(1, 18));
            ef  = (rf && rls) ? !m_last_f : rf;
            et  = (rk > int'(TO));
            erd = (!et && (ef || rrw)) ? rmv : m_rdata;
            do_txn(rf, rls, rrw, rfa, rla, rwd, rmv, rk, ef, et, erd,
                   1'($urandom), 1'($urandom), 2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
